// File: rtl/out_port_fifo_pkg.sv
// Shared constants for the core bus and the output-port FIFO.
// Also provides a constant log2 helper used to size pointers.
package out_port_fifo_pkg;

    localparam int unsigned P_BUS_WIDTH = 16;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((64'd1 << res) < 64'(value)) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/out_port_fifo.sv
// Output-port FIFO: buffers core out_port words strobed by outEn and
// presents them show-ahead to a valid/ready consumer, with a sticky overflow flag.
module out_port_fifo
    import out_port_fifo_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = P_BUS_WIDTH,
    parameter int unsigned DEPTH     = 8,
    localparam int unsigned ADDR_W   = clog2(DEPTH)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_wr_en,
    input  logic [BUS_WIDTH-1:0] i_wr_data,
    output logic                 o_full,
    output logic                 o_rd_valid,
    input  logic                 i_rd_ready,
    output logic [BUS_WIDTH-1:0] o_rd_data,
    output logic [ADDR_W:0]      o_count,
    output logic                 o_overflow,
    input  logic                 i_clr_ovf
);

    logic [BUS_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0]    r_wr_ptr;
    logic [ADDR_W-1:0]    r_rd_ptr;
    logic [ADDR_W:0]      r_count;
    logic                 r_overflow;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;
    logic [ADDR_W:0]      w_count_nxt;

    assign w_full  = (r_count == (ADDR_W + 1)'(DEPTH));
    assign w_empty = (r_count == '0);

    // A pop frees a slot on the same edge, so a write at full still fits.
    assign w_pop  = !w_empty && i_rd_ready;
    assign w_push = i_wr_en && (!w_full || w_pop);
    assign w_drop = i_wr_en && w_full && !w_pop;

    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Storage is deliberately not reset; the output mask hides stale contents.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    assign o_full     = w_full;
    assign o_rd_valid = !w_empty;
    assign o_rd_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule
